// File: rtl/weight_dma_multibank.sv
// Weight-load DMA: streams a conv weight block to the conv SRAM and an FC
// weight block round-robin across N_BANK FC SRAM banks, with a
// configurable source read latency, abort and length-error detection.
module weight_dma_multibank #(
  parameter int DW      = 16,
  parameter int AW      = 16,
  parameter int N_BANK  = 4,
  parameter int BANK_AW = 11,
  parameter int CONV_AW = 10,
  parameter int RD_LAT  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic [AW-1:0]       i_src_base,
  input  logic [AW-1:0]       i_conv_len,
  input  logic [AW-1:0]       i_fc_len,
  output logic                o_src_rd,
  output logic [AW-1:0]       o_src_addr,
  input  logic [DW-1:0]       i_src_data,
  output logic                o_conv_we,
  output logic [CONV_AW-1:0]  o_conv_addr,
  output logic [N_BANK-1:0]   o_fc_we,
  output logic [BANK_AW-1:0]  o_fc_addr,
  output logic [DW-1:0]       o_wdata,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err
);

  localparam int BW  = (N_BANK > 1) ? $clog2(N_BANK) : 1;
  localparam int TAW = (BANK_AW > CONV_AW) ? BANK_AW : CONV_AW;
  localparam logic [AW:0] CONV_MAX = (AW+1)'(1) << CONV_AW;
  localparam logic [AW:0] FC_MAX   = (AW+1)'(1) << BANK_AW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_CONV,
    S_FC,
    S_DRAIN
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     src_addr_q;
  logic [AW-1:0]     conv_len_q;
  logic [AW-1:0]     fc_len_q;
  logic [AW-1:0]     conv_idx_q;
  logic [AW-1:0]     fc_idx_q;
  logic [BW-1:0]     fc_bank_q;
  logic              err_q;

  // Tag pipeline: one stage per cycle of source read latency.
  logic [RD_LAT-1:0] pv_q;
  logic [RD_LAT-1:0] pc_q;
  logic [BW-1:0]     pb_q [RD_LAT];
  logic [TAW-1:0]    pa_q [RD_LAT];

  logic abort_eff;
  logic rd;
  logic len_err;
  logic conv_last;
  logic fc_last;
  logic wr;

  assign abort_eff = i_abort & (state_q != S_IDLE);
  assign rd        = ((state_q == S_CONV) | (state_q == S_FC)) & ~abort_eff;
  assign len_err   = ({1'b0, conv_len_q} > CONV_MAX) | ({1'b0, fc_len_q} > FC_MAX);
  assign conv_last = (conv_idx_q == conv_len_q - AW'(1));
  assign fc_last   = (fc_bank_q == BW'(N_BANK - 1)) & (fc_idx_q == fc_len_q - AW'(1));
  assign wr        = pv_q[RD_LAT-1] & ~abort_eff;

  assign o_src_rd    = rd;
  assign o_src_addr  = src_addr_q;
  assign o_conv_we   = wr & pc_q[RD_LAT-1];
  assign o_conv_addr = pa_q[RD_LAT-1][CONV_AW-1:0];
  assign o_fc_we     = (wr & ~pc_q[RD_LAT-1]) ? (N_BANK'(1) << pb_q[RD_LAT-1]) : '0;
  assign o_fc_addr   = pa_q[RD_LAT-1][BANK_AW-1:0];
  assign o_wdata     = wr ? i_src_data : '0;
  assign o_busy      = (state_q != S_IDLE);
  assign o_err       = err_q;
  // Done is the final DRAIN cycle: the last write landed in the previous cycle.
  assign o_done      = (state_q == S_DRAIN) & (pv_q == '0) & ~i_abort;

  // Next-state selection; abort overrides every non-IDLE state.
  always_comb begin
    state_d = state_q;
    if (abort_eff) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (i_start) state_d = S_CHECK;
        S_CHECK: begin
          if (len_err)               state_d = S_IDLE;
          else if (conv_len_q != '0) state_d = S_CONV;
          else if (fc_len_q != '0)   state_d = S_FC;
          else                       state_d = S_DRAIN;
        end
        S_CONV:  if (conv_last) state_d = (fc_len_q != '0) ? S_FC : S_DRAIN;
        S_FC:    if (fc_last) state_d = S_DRAIN;
        S_DRAIN: if (pv_q == '0) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, transfer counters, error flag and tag pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      src_addr_q <= '0;
      conv_len_q <= '0;
      fc_len_q   <= '0;
      conv_idx_q <= '0;
      fc_idx_q   <= '0;
      fc_bank_q  <= '0;
      err_q      <= 1'b0;
      pv_q       <= '0;
      pc_q       <= '0;
      for (int unsigned i = 0; i < unsigned'(RD_LAT); i++) begin
        pb_q[i] <= '0;
        pa_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;

      if ((state_q == S_IDLE) && i_start) begin
        src_addr_q <= i_src_base;
        conv_len_q <= i_conv_len;
        fc_len_q   <= i_fc_len;
        conv_idx_q <= '0;
        fc_idx_q   <= '0;
        fc_bank_q  <= '0;
        err_q      <= 1'b0;
      end

      if ((state_q == S_CHECK) && !abort_eff && len_err) begin
        err_q <= 1'b1;
      end

      if (rd) begin
        src_addr_q <= src_addr_q + AW'(1);
        if (state_q == S_CONV) begin
          conv_idx_q <= conv_idx_q + AW'(1);
        end else if (fc_bank_q == BW'(N_BANK - 1)) begin
          fc_bank_q <= '0;
          fc_idx_q  <= fc_idx_q + AW'(1);
        end else begin
          fc_bank_q <= fc_bank_q + BW'(1);
        end
      end

      if (abort_eff) begin
        pv_q <= '0;
      end else begin
        for (int unsigned i = 1; i < unsigned'(RD_LAT); i++) begin
          pv_q[i] <= pv_q[i-1];
        end
        pv_q[0] <= rd;
      end
      for (int unsigned i = 1; i < unsigned'(RD_LAT); i++) begin
        pc_q[i] <= pc_q[i-1];
        pb_q[i] <= pb_q[i-1];
        pa_q[i] <= pa_q[i-1];
      end
      pc_q[0] <= (state_q == S_CONV);
      pb_q[0] <= (state_q == S_CONV) ? '0 : fc_bank_q;
      pa_q[0] <= (state_q == S_CONV) ? TAW'(conv_idx_q) : TAW'(fc_idx_q);
    end
  end

endmodule

// File: tb/tb_weight_dma_multibank.sv
// Bench for weight_dma_multibank: two instances (RD_LAT=1 and RD_LAT=3)
// share stimulus; a queue scoreboard checks every read and write.
module tb_weight_dma_multibank;

  localparam int NB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [15:0] base, conv_len, fc_len;

  logic        rd    [2];
  logic [15:0] sa    [2];
  logic [15:0] sdata [2];
  logic        cwe   [2];
  logic [9:0]  ca    [2];
  logic [3:0]  fwe   [2];
  logic [10:0] fa    [2];
  logic [15:0] wd    [2];
  logic        busy  [2];
  logic        done  [2];
  logic        err   [2];

  always #5 clk = ~clk;

  weight_dma_multibank #(.RD_LAT(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_src_base(base), .i_conv_len(conv_len), .i_fc_len(fc_len),
    .o_src_rd(rd[0]), .o_src_addr(sa[0]), .i_src_data(sdata[0]),
    .o_conv_we(cwe[0]), .o_conv_addr(ca[0]), .o_fc_we(fwe[0]), .o_fc_addr(fa[0]),
    .o_wdata(wd[0]), .o_busy(busy[0]), .o_done(done[0]), .o_err(err[0]));

  weight_dma_multibank #(.RD_LAT(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_src_base(base), .i_conv_len(conv_len), .i_fc_len(fc_len),
    .o_src_rd(rd[1]), .o_src_addr(sa[1]), .i_src_data(sdata[1]),
    .o_conv_we(cwe[1]), .o_conv_addr(ca[1]), .o_fc_we(fwe[1]), .o_fc_addr(fa[1]),
    .o_wdata(wd[1]), .o_busy(busy[1]), .o_done(done[1]), .o_err(err[1]));

  function automatic logic [15:0] srcval(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  // Source memory models with the matching read latency.
  logic [15:0] m0;
  logic [15:0] m1 [3];
  always @(posedge clk) begin
    m0    <= srcval(sa[0]);
    m1[0] <= srcval(sa[1]);
    m1[1] <= m1[0];
    m1[2] <= m1[1];
  end
  assign sdata[0] = m0;
  assign sdata[1] = m1[2];

  typedef struct packed {
    logic        cv;
    logic [1:0]  bk;
    logic [10:0] ad;
    logic [15:0] dt;
  } wr_t;

  typedef struct {
    logic [15:0] base;
    logic [15:0] conv;
    logic [15:0] fc;
    logic        err;
  } vec_t;

  logic [15:0] rq [2][$];
  wr_t         wq [2][$];

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int t0     = 0;
  int first_rd [2];
  int last_rd  [2];
  int done_rel [2];
  int done_cnt [2];
  int busy_cnt [2];

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d cyc=%0d actual=%0h required=%0h", nm, d, cyc, act, exp);
    end
  endtask

  task automatic mon();
    for (int d = 0; d < 2; d++) begin
      if (rd[d] === 1'b1) begin
        if (rq[d].size() == 0) chk("unexpected_rd", d, 32'(sa[d]), 32'hFFFFFFFF);
        else chk("rd_addr", d, 32'(sa[d]), 32'(rq[d].pop_front()));
        if (first_rd[d] < 0) first_rd[d] = cyc - t0;
        last_rd[d] = cyc - t0;
      end
      if ((32'(cwe[d]) + 32'($countones(fwe[d]))) > 1)
        chk("we_onehot", d, {cwe[d], fwe[d]}, 0);
      if (cwe[d] || (fwe[d] != 0)) begin
        wr_t a;
        a.cv = cwe[d];
        a.bk = 2'd0;
        for (int b = 0; b < NB; b++) if (fwe[d][b]) a.bk = 2'(b);
        a.ad = cwe[d] ? {1'b0, ca[d]} : fa[d];
        a.dt = wd[d];
        if (wq[d].size() == 0) chk("unexpected_wr", d, 32'(a), 32'hFFFFFFFF);
        else chk("wr_tag_data", d, 32'(a), 32'(wq[d].pop_front()));
      end
      if (done[d]) begin
        done_cnt[d]++;
        done_rel[d] = cyc - t0;
      end
      if (busy[d]) busy_cnt[d]++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    mon();
  endtask

  task automatic flush();
    for (int d = 0; d < 2; d++) begin
      rq[d].delete();
      wq[d].delete();
    end
  endtask

  // Start a transfer; expected reads/writes are queued up front.
  task automatic launch(input logic [15:0] b, input logic [15:0] cl, input logic [15:0] fl,
                        input bit expect_ok);
    base = b; conv_len = cl; fc_len = fl; start = 1'b1;
    t0 = cyc;
    for (int d = 0; d < 2; d++) begin
      first_rd[d] = -1; last_rd[d] = -1; done_rel[d] = -1;
      done_cnt[d] = 0;  busy_cnt[d] = 0;
      if (expect_ok) begin
        for (int k = 0; k < int'(cl); k++) begin
          logic [15:0] a = b + 16'(k);
          rq[d].push_back(a);
          wq[d].push_back({1'b1, 2'd0, 11'(k), srcval(a)});
        end
        for (int j = 0; j < NB * int'(fl); j++) begin
          logic [15:0] a = b + cl + 16'(j);
          rq[d].push_back(a);
          wq[d].push_back({1'b0, 2'(j % NB), 11'(j / NB), srcval(a)});
        end
      end
    end
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy[0] || busy[1]) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) chk("idle_timeout", 0, 1, 0);
    step();
    step();
  endtask

  task automatic end_checks(input logic exp_err);
    for (int d = 0; d < 2; d++) begin
      chk("err", d, 32'(err[d]), 32'(exp_err));
      chk("done_cnt", d, done_cnt[d], exp_err ? 0 : 1);
      chk("rd_left", d, rq[d].size(), 0);
      chk("wr_left", d, wq[d].size(), 0);
    end
  endtask

  task automatic chk_zero_outs(input string nm);
    for (int d = 0; d < 2; d++)
      chk(nm, d, {rd[d], busy[d], done[d], err[d], cwe[d], |fwe[d],
                  |sa[d], |ca[d], |fa[d], |wd[d]}, 0);
  endtask

  vec_t vecs [8];

  initial begin
    vecs[0] = '{16'h0100, 16'd3,    16'd2,    1'b0};
    vecs[1] = '{16'hFFFE, 16'd4,    16'd0,    1'b0};
    vecs[2] = '{16'h1234, 16'd0,    16'd3,    1'b0};
    vecs[3] = '{16'h0000, 16'd1024, 16'd1,    1'b0};
    vecs[4] = '{16'h0500, 16'd1025, 16'd1,    1'b1};
    vecs[5] = '{16'h0600, 16'd2,    16'd2049, 1'b1};
    vecs[6] = '{16'h0700, 16'd0,    16'd2048, 1'b0};
    vecs[7] = '{16'h0010, 16'd5,    16'd1,    1'b0};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    base = '0; conv_len = '0; fc_len = '0;
    for (int d = 0; d < 2; d++) begin
      first_rd[d] = -1; last_rd[d] = -1; done_rel[d] = -1;
      done_cnt[d] = 0;  busy_cnt[d] = 0;
    end
    @(negedge clk);
    #1;
    chk_zero_outs("reset_outs");
    step();
    rst_n = 1'b1;
    step();

    // Reference transfer: exact read window and done cycle.
    launch(16'h0100, 16'd3, 16'd2, 1'b1);
    wait_idle(200);
    end_checks(1'b0);
    for (int d = 0; d < 2; d++) begin
      chk("first_rd_cyc", d, first_rd[d], 2);
      chk("last_rd_cyc", d, last_rd[d], 12);
    end
    chk("done_cyc", 0, done_rel[0], 14);
    chk("done_cyc", 1, done_rel[1], 16);

    // Zero-length transfer.
    launch(16'h0200, 16'd0, 16'd0, 1'b1);
    wait_idle(50);
    end_checks(1'b0);
    for (int d = 0; d < 2; d++) begin
      chk("zero_done_cyc", d, done_rel[d], 2);
      chk("zero_busy_cycles", d, busy_cnt[d], 2);
      chk("zero_no_rd", d, first_rd[d], -1);
    end

    // Table of transfers, including boundary lengths and wraparound.
    for (int i = 0; i < 8; i++) begin
      launch(vecs[i].base, vecs[i].conv, vecs[i].fc, !vecs[i].err);
      wait_idle(20000);
      end_checks(vecs[i].err);
    end

    // Start while busy is ignored (extra pulse mid-transfer).
    launch(16'h0800, 16'd2, 16'd1, 1'b1);
    step();
    start = 1'b1; conv_len = 16'd9;
    step();
    start = 1'b0;
    wait_idle(200);
    end_checks(1'b0);

    // Abort two cycles after the first FC read.
    launch(16'h2000, 16'd2, 16'd3, 1'b1);
    repeat (5) step();
    abort = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("abort_rd_drop", d, 32'(rd[d]), 0);
      chk("abort_no_we", d, {cwe[d], fwe[d]}, 0);
    end
    flush();
    step();
    abort = 1'b0;
    for (int d = 0; d < 2; d++) chk("abort_busy", d, 32'(busy[d]), 0);
    repeat (5) step();
    for (int d = 0; d < 2; d++) begin
      chk("abort_no_done", d, done_cnt[d], 0);
      chk("abort_err", d, 32'(err[d]), 0);
    end

    // Reset asserted mid-FC, then a clean transfer.
    launch(16'h3000, 16'd2, 16'd4, 1'b1);
    repeat (6) step();
    rst_n = 1'b0;
    #1;
    chk_zero_outs("midrun_reset_outs");
    flush();
    step();
    step();
    rst_n = 1'b1;
    step();
    launch(16'h3100, 16'd3, 16'd2, 1'b1);
    wait_idle(200);
    end_checks(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
